// File: rtl/ls165_reader.sv
// ls165_reader: drives an external 8-bit PISO shift register (74HC165-style)
// and hands each captured byte downstream over a valid/ready port.
// The shift register is clocked by the same cp; this block controls it
// through the active-low parallel load (pl_) and the clock inhibit (inh).
// Every output comes straight from a flop, so no input reaches an output
// through combinational logic.

module ls165_reader #(
    parameter bit MSB_FIRST = 1'b1,
    parameter bit AUTO      = 1'b0
) (
    input  logic       cp,
    input  logic       mr,
    input  logic       start,
    input  logic       ser_in,
    input  logic       drdy,
    output logic       pl_,
    output logic       inh,
    output logic [7:0] dout,
    output logic       dvalid,
    output logic       busy,
    output logic       ovr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] cnt;
    logic [7:0] asm_reg;
    logic [7:0] shifted;
    logic       complete;

    // The byte as it will look once the current ser_in sample is included.
    // The first sample is stage 7, so MSB-first shifts left and LSB-first
    // shifts right.
    always_comb begin
        shifted = 8'h00;
        if (MSB_FIRST) begin
            shifted = {asm_reg[6:0], ser_in};
        end else begin
            shifted = {ser_in, asm_reg[7:1]};
        end
        complete = (state == SHIFT) && (cnt == 3'd7);
    end

    // Capture sequencer plus output handshake, all registered.
    always_ff @(posedge cp or posedge mr) begin
        if (mr) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            asm_reg <= 8'h00;
            pl_     <= 1'b1;
            inh     <= 1'b1;
            busy    <= 1'b0;
            dout    <= 8'h00;
            dvalid  <= 1'b0;
            ovr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start || AUTO) begin
                        state <= LOAD;
                        pl_   <= 1'b0;
                        inh   <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state <= SHIFT;
                    cnt   <= 3'd0;
                    pl_   <= 1'b1;
                    inh   <= 1'b0;
                end
                SHIFT: begin
                    asm_reg <= shifted;
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state <= IDLE;
                        inh   <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    pl_   <= 1'b1;
                    inh   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase

            // A finished byte is only accepted when the output slot is free
            // or being emptied on this same edge; otherwise it is dropped
            // and the sticky overrun flag records the loss.
            if (complete) begin
                if (!dvalid || drdy) begin
                    dout   <= shifted;
                    dvalid <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (dvalid && drdy) begin
                dvalid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ls165_reader.sv
// tb_ls165_reader: three instances (MSB-first, LSB-first, AUTO) each fed by
// a behavioural 74HC165 model; table-driven captures, hand-written
// corner-case sequences and a randomized run against a countdown model.

module tb_ls165_reader;

    logic       cp = 1'b0;
    logic       mr = 1'b1;
    logic [2:0] start = 3'b000;
    logic [2:0] drdy = 3'b000;
    logic [7:0] par [3];
    logic [7:0] sr [3];

    logic [2:0] pl_o;
    logic [2:0] inh_o;
    logic [2:0] dvalid_o;
    logic [2:0] busy_o;
    logic [2:0] ovr_o;
    logic [7:0] dout_o [3];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int         inst;
        logic [7:0] word;
        logic [7:0] expect_dout;
    } vec_t;

    vec_t table_v [6];

    always #5 cp = ~cp;

    ls165_reader #(.MSB_FIRST(1'b1), .AUTO(1'b0)) u_msb (
        .cp(cp), .mr(mr), .start(start[0]), .ser_in(sr[0][7]), .drdy(drdy[0]),
        .pl_(pl_o[0]), .inh(inh_o[0]), .dout(dout_o[0]), .dvalid(dvalid_o[0]),
        .busy(busy_o[0]), .ovr(ovr_o[0])
    );

    ls165_reader #(.MSB_FIRST(1'b0), .AUTO(1'b0)) u_lsb (
        .cp(cp), .mr(mr), .start(start[1]), .ser_in(sr[1][7]), .drdy(drdy[1]),
        .pl_(pl_o[1]), .inh(inh_o[1]), .dout(dout_o[1]), .dvalid(dvalid_o[1]),
        .busy(busy_o[1]), .ovr(ovr_o[1])
    );

    ls165_reader #(.MSB_FIRST(1'b1), .AUTO(1'b1)) u_auto (
        .cp(cp), .mr(mr), .start(start[2]), .ser_in(sr[2][7]), .drdy(drdy[2]),
        .pl_(pl_o[2]), .inh(inh_o[2]), .dout(dout_o[2]), .dvalid(dvalid_o[2]),
        .busy(busy_o[2]), .ovr(ovr_o[2])
    );

    // External shift register model: load while pl_ is low, shift stage n
    // into stage n+1 when not inhibited; stage 7 drives ser_in.
    always @(posedge cp) begin
        for (int k = 0; k < 3; k++) begin
            if (!pl_o[k]) begin
                sr[k] <= par[k];
            end else if (!inh_o[k]) begin
                sr[k] <= {sr[k][6:0], 1'b0};
            end
        end
    end

    function automatic logic [7:0] reverse8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7 - i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp_v);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp_v);
        vectors++;
        if (act != exp_v) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Pulse mr between clock edges and check all instances before any edge.
    task automatic doReset(input string tag);
        @(negedge cp);
        mr = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("%s rst pl_[%0d]", tag, k), 8'(pl_o[k]), 8'h01);
            checkOutput($sformatf("%s rst inh[%0d]", tag, k), 8'(inh_o[k]), 8'h01);
            checkOutput($sformatf("%s rst dout[%0d]", tag, k), dout_o[k], 8'h00);
            checkOutput($sformatf("%s rst dvalid[%0d]", tag, k), 8'(dvalid_o[k]), 8'h00);
            checkOutput($sformatf("%s rst busy[%0d]", tag, k), 8'(busy_o[k]), 8'h00);
            checkOutput($sformatf("%s rst ovr[%0d]", tag, k), 8'(ovr_o[k]), 8'h00);
        end
        @(negedge cp);
        mr = 1'b0;
    endtask

    // One start-triggered capture with drdy=1, checking timing and the byte.
    task automatic applyStimulus(input int k, input logic [7:0] word,
                                 input logic [7:0] exp_dout, input string tag);
        int pl_low;
        int inh_low;
        @(negedge cp);
        par[k]   = word;
        drdy[k]  = 1'b1;
        start[k] = 1'b1;
        @(posedge cp);
        #1 start[k] = 1'b0;
        pl_low  = 0;
        inh_low = 0;
        for (int i = 0; i < 11; i++) begin
            @(negedge cp);
            if (!pl_o[k]) pl_low++;
            if (!inh_o[k]) inh_low++;
            if (i == 0) checkOutput({tag, " pl_ after E0"}, 8'(pl_o[k]), 8'h00);
            if (i == 8) checkOutput({tag, " busy after E8"}, 8'(busy_o[k]), 8'h01);
            if (i == 9) begin
                checkOutput({tag, " dout at E9"}, dout_o[k], exp_dout);
                checkOutput({tag, " dvalid at E9"}, 8'(dvalid_o[k]), 8'h01);
                checkOutput({tag, " busy at E9"}, 8'(busy_o[k]), 8'h00);
            end
            if (i == 10) checkOutput({tag, " dvalid at E10"}, 8'(dvalid_o[k]), 8'h00);
        end
        checkCount({tag, " pl_ low cycles"}, pl_low, 1);
        checkCount({tag, " inh low cycles"}, inh_low, 8);
    endtask

    // AUTO instance with drdy held low: first byte kept, second dropped.
    task automatic autoSequence();
        @(negedge cp);
        mr      = 1'b1;
        par[2]  = 8'h12;
        drdy[2] = 1'b0;
        @(negedge cp);
        mr = 1'b0;
        @(posedge cp);
        @(negedge cp);
        checkOutput("auto pl_ after E0", 8'(pl_o[2]), 8'h00);
        checkOutput("auto busy after E0", 8'(busy_o[2]), 8'h01);
        @(posedge cp);
        @(negedge cp);
        par[2] = 8'h34;
        repeat (8) @(posedge cp);
        @(negedge cp);
        checkOutput("auto first dout", dout_o[2], 8'h12);
        checkOutput("auto first dvalid", 8'(dvalid_o[2]), 8'h01);
        checkOutput("auto first ovr", 8'(ovr_o[2]), 8'h00);
        @(posedge cp);
        @(negedge cp);
        checkOutput("auto restart pl_ at E10", 8'(pl_o[2]), 8'h00);
        repeat (9) @(posedge cp);
        @(negedge cp);
        checkOutput("auto second ovr", 8'(ovr_o[2]), 8'h01);
        checkOutput("auto second dout held", dout_o[2], 8'h12);
        checkOutput("auto second dvalid held", 8'(dvalid_o[2]), 8'h01);
        drdy[2] = 1'b1;
        @(posedge cp);
        @(negedge cp);
        drdy[2] = 1'b0;
        checkOutput("auto dvalid after drdy", 8'(dvalid_o[2]), 8'h00);
        checkOutput("auto ovr sticky", 8'(ovr_o[2]), 8'h01);
    endtask

    // Randomized run on the two start-driven instances against a model that
    // only tracks cycles remaining until the byte completes.
    task automatic randomRun(input int cycles);
        int         rem [2];
        logic [7:0] cap [2];
        logic [7:0] m_dout [2];
        logic       m_v [2];
        logic       m_ovr [2];
        logic       done;
        doReset("rand");
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; cap[k] = 8'h00; m_dout[k] = 8'h00; m_v[k] = 1'b0; m_ovr[k] = 1'b0;
        end
        for (int c = 0; c < cycles; c++) begin
            @(negedge cp);
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("rand[%0d] c%0d dout", k, c), dout_o[k], m_dout[k]);
                checkOutput($sformatf("rand[%0d] c%0d dvalid", k, c), 8'(dvalid_o[k]), 8'(m_v[k]));
                checkOutput($sformatf("rand[%0d] c%0d ovr", k, c), 8'(ovr_o[k]), 8'(m_ovr[k]));
                checkOutput($sformatf("rand[%0d] c%0d busy", k, c), 8'(busy_o[k]), 8'(rem[k] > 0));
                checkOutput($sformatf("rand[%0d] c%0d pl_", k, c), 8'(pl_o[k]), 8'(rem[k] != 9));
                checkOutput($sformatf("rand[%0d] c%0d inh", k, c), 8'(inh_o[k]),
                            8'(!(rem[k] >= 1 && rem[k] <= 8)));
                drdy[k] = ($urandom_range(0, 3) == 0);
                if (rem[k] == 0) begin
                    par[k]   = 8'($urandom);
                    start[k] = ($urandom_range(0, 3) == 0);
                end else begin
                    start[k] = ($urandom_range(0, 1) == 1);
                end
                done = 1'b0;
                if (rem[k] == 0) begin
                    if (start[k]) begin
                        rem[k] = 9;
                        cap[k] = (k == 0) ? par[k] : reverse8(par[k]);
                    end
                end else begin
                    rem[k]--;
                    if (rem[k] == 0) done = 1'b1;
                end
                if (done) begin
                    if (!m_v[k] || drdy[k]) begin
                        m_dout[k] = cap[k];
                        m_v[k]    = 1'b1;
                    end else begin
                        m_ovr[k] = 1'b1;
                    end
                end else if (m_v[k] && drdy[k]) begin
                    m_v[k] = 1'b0;
                end
            end
        end
        @(negedge cp);
        start = 3'b000;
        drdy  = 3'b000;
    endtask

    // Re-pulsed start is ignored; mr mid-shift aborts with no partial byte.
    task automatic restartAndAbort();
        int busy_cnt;
        doReset("abort");
        @(negedge cp);
        par[0]   = 8'h5A;
        drdy[0]  = 1'b0;
        start[0] = 1'b1;
        @(posedge cp);
        #1 start[0] = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge cp);
            if (busy_o[0]) busy_cnt++;
            if (i == 3) start[0] = 1'b1;
            if (i == 4) start[0] = 1'b0;
        end
        checkCount("repulse busy cycles", busy_cnt, 9);
        checkOutput("repulse dout", dout_o[0], 8'h5A);
        checkOutput("repulse dvalid held", 8'(dvalid_o[0]), 8'h01);
        @(negedge cp);
        par[0]   = 8'hC3;
        start[0] = 1'b1;
        @(posedge cp);
        #1 start[0] = 1'b0;
        repeat (5) @(posedge cp);
        #1 mr = 1'b1;
        #1;
        checkOutput("abort dout", dout_o[0], 8'h00);
        checkOutput("abort dvalid", 8'(dvalid_o[0]), 8'h00);
        checkOutput("abort busy", 8'(busy_o[0]), 8'h00);
        checkOutput("abort inh", 8'(inh_o[0]), 8'h01);
        checkOutput("abort pl_", 8'(pl_o[0]), 8'h01);
        @(negedge cp);
        mr = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge cp);
            checkOutput($sformatf("post-abort idle busy %0d", i), 8'(busy_o[0]), 8'h00);
            checkOutput($sformatf("post-abort dvalid %0d", i), 8'(dvalid_o[0]), 8'h00);
        end
        applyStimulus(0, 8'h3C, 8'h3C, "after abort 3C");
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            par[k] = 8'h00;
            sr[k]  = 8'h00;
        end
        table_v[0] = '{inst: 0, word: 8'hA5, expect_dout: 8'hA5};
        table_v[1] = '{inst: 1, word: 8'h01, expect_dout: 8'h80};
        table_v[2] = '{inst: 0, word: 8'h3C, expect_dout: 8'h3C};
        table_v[3] = '{inst: 1, word: 8'hC8, expect_dout: 8'h13};
        table_v[4] = '{inst: 1, word: 8'h80, expect_dout: 8'h01};
        table_v[5] = '{inst: 0, word: 8'hFF, expect_dout: 8'hFF};

        doReset("init");
        for (int v = 0; v < 6; v++) begin
            applyStimulus(table_v[v].inst, table_v[v].word, table_v[v].expect_dout,
                          $sformatf("vec%0d", v));
        end
        autoSequence();
        randomRun(600);
        restartAndAbort();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ls165_reader.md
LS165_READER -- requirements
Module: ls165_reader

Interface
- REQ-001: The block SHALL drive an external 8-bit parallel-in/serial-out shift register and return each captured byte over a valid/ready port.
- REQ-002: Parameter MSB_FIRST, default 1, meaning the first serial bit lands in dout[7]; when 0 it lands in dout[0].
- REQ-003: Parameter AUTO, default 0, meaning when 1 a new capture starts from IDLE without start.
- REQ-004: cp  input  1  clock, rising-edge; the shift register SHALL share this clock.
- REQ-005: mr  input  1  master reset, asynchronous, active-high.
- REQ-006: start  input  1  request one capture; sampled only in IDLE.
- REQ-007: ser_in  input  1  serial data from the shift register's last-stage output.
- REQ-008: pl_  output  1  parallel load to the shift register, active-low.
- REQ-009: inh  output  1  clock inhibit to the shift register; 1 = hold, 0 = shift.
- REQ-010: dout  output  8  captured byte.
- REQ-011: dvalid  output  1  dout holds an unconsumed byte.
- REQ-012: drdy  input  1  downstream accepts dout on a rising edge when dvalid=1.
- REQ-013: busy  output  1  capture in progress (LOAD or SHIFT).
- REQ-014: ovr  output  1  sticky overrun flag.

Function
- REQ-015: The block SHALL register every output; no output SHALL depend combinationally on any input.
- REQ-016: FSM states SHALL be IDLE, LOAD and SHIFT.
- REQ-017: IDLE SHALL drive pl_=1 and inh=1, and SHALL go to LOAD on an edge where start=1 or AUTO=1.
- REQ-018: LOAD SHALL last exactly one cycle with pl_=0 and inh=1, and SHALL then go to SHIFT with bit counter cleared to 0.
- REQ-019: SHIFT SHALL drive pl_=1 and inh=0 for exactly 8 cycles.
- REQ-020: On each rising edge in SHIFT, the block SHALL sample ser_in into the assembly register and increment the 3-bit counter.
- REQ-021: On the edge taking the 8th sample (counter=7), the FSM SHALL return to IDLE and drive inh=1.
- REQ-022: Bit order: first sample = shift register stage 7, last sample = stage 0.
- REQ-023: With MSB_FIRST=1 the samples SHALL fill dout[7] down to dout[0]; with MSB_FIRST=0, dout[0] up to dout[7].
- REQ-024: Latency: start sampled at edge E0 SHALL give pl_ low from E0 to E1, inh low from E1 to E9, and dout/dvalid updated at E9 (9 cycles after E0).
- REQ-025: AUTO=1 SHALL give a capture period of 10 cycles.
- REQ-026: Handshake: at E9, dout SHALL load and dvalid SHALL go to 1 if dvalid=0 or drdy=1 on that edge.
- REQ-027: A transfer occurs on an edge with dvalid=1 and drdy=1; if no new byte completes on that edge, dvalid SHALL go to 0.
- REQ-028: dout SHALL stay stable while dvalid=1 and no transfer occurs.
- REQ-029: Overrun: if a byte completes while dvalid=1 and drdy=0, the new byte SHALL be dropped and ovr SHALL be set to 1 until mr.
- REQ-030: start asserted in LOAD or SHIFT SHALL be ignored, not queued.
- REQ-031: busy SHALL be 1 exactly in LOAD and SHIFT.

Reset
- REQ-032: While mr=1, outputs SHALL immediately be pl_=1, inh=1, dout=8'h00, dvalid=0, busy=0, ovr=0, with state IDLE and counter 0, independent of cp.
- REQ-033: mr asserted mid-capture SHALL abort it; no partial byte SHALL ever appear on dout.
- REQ-034: After mr deasserts, the first capture SHALL need a fresh start, or AUTO=1.

Verification
- REQ-035: Reset: mr=1 pulse with random prior state -> pl_=1, inh=1, dout=00, dvalid=0, busy=0, ovr=0 with no clock edge.
- REQ-036: Shift register model loaded with 8'hA5, MSB_FIRST=1, start pulse at E0, drdy=1 -> pl_ low for 1 cycle, inh low for exactly 8 cycles, dout=A5 and dvalid=1 at E9, dvalid=0 at E10.
- REQ-037: MSB_FIRST=0, model loaded with 8'h01 -> dout=8'h80 at E9.
- REQ-038: AUTO=1, drdy=0, model words 8'h12 then 8'h34 -> dout=12 with dvalid held, ovr=1 after the second completion, dout still 12; then drdy=1 for one cycle -> dvalid=0.
- REQ-039: start re-pulsed during SHIFT -> single capture only, busy=1 for 9 cycles; then mr at the 4th SHIFT sample -> reset values, and the next start with 8'h3C -> dout=3C.
